// File: rtl/boot_sequencer_if.sv
// Byte-stream load port of the boot sequencer: the image source is master, the sequencer is slave.
interface boot_sequencer_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_ready;

    modport master (output byte_valid, byte_data, byte_last, input byte_ready);
    modport slave  (input byte_valid, byte_data, byte_last, output byte_ready);
endinterface

// File: rtl/boot_sequencer.sv
// Loads a little-endian byte image into core memory, releases the core, then supervises a0/timeout.
// Optional restart from DONE enabled by defining BOOT_SEQ_RERUN_EN.
module boot_sequencer #(
    parameter int WIDTH          = 32,
    parameter int MAX_WORDS      = 1024,
    parameter int HOLD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic               clock,
    input  logic               reset,
    boot_sequencer_if.slave    stream,
    input  logic [WIDTH-1:0]   expected_a0,
    input  logic [WIDTH-1:0]   a0,
    input  logic               rerun,
    output logic               memEn,
    output logic [WIDTH-1:0]   memAddr,
    output logic [WIDTH-1:0]   memData,
    output logic               core_reset,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic               load_err,
    output logic [31:0]        cycle_count
);

    localparam logic [2:0] LOAD  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] HOLD  = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(MAX_WORDS - 1);
    localparam logic [31:0]      HOLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0]      RUN_LIMIT = 32'(TIMEOUT_CYCLES);

    logic [2:0]       state;
    logic [1:0]       byte_cnt;
    logic [WIDTH-1:0] word_addr;
    logic [WIDTH-1:0] asm_word;
    logic [WIDTH-1:0] merged;
    logic             last_seen;
    logic [31:0]      hold_cnt;

`ifndef BOOT_SEQ_RERUN_EN
    logic rerun_unused;
    assign rerun_unused = rerun;
`endif

    // Unfilled bytes stay zero because the assembly register is cleared after every write.
    always_comb begin
        merged = asm_word | (WIDTH'(stream.byte_data) << {byte_cnt, 3'b000});
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= LOAD;
            byte_cnt          <= 2'd0;
            word_addr         <= '0;
            asm_word          <= '0;
            last_seen         <= 1'b0;
            hold_cnt          <= '0;
            memEn             <= 1'b0;
            memAddr           <= '0;
            memData           <= '0;
            core_reset        <= 1'b1;
            stream.byte_ready <= 1'b1;
            busy              <= 1'b1;
            done              <= 1'b0;
            pass              <= 1'b0;
            timeout           <= 1'b0;
            load_err          <= 1'b0;
            cycle_count       <= '0;
        end else begin
            memEn <= 1'b0;
            case (state)
                LOAD: begin
                    if (stream.byte_valid && stream.byte_ready) begin
                        asm_word <= merged;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3 || stream.byte_last) begin
                            state             <= WRITE;
                            last_seen         <= stream.byte_last;
                            stream.byte_ready <= 1'b0;
                            memEn             <= 1'b1;
                            memAddr           <= word_addr;
                            memData           <= merged;
                        end
                    end
                end
                WRITE: begin
                    word_addr <= word_addr + 1'b1;
                    byte_cnt  <= 2'd0;
                    asm_word  <= '0;
                    if (last_seen) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end else if (word_addr == LAST_ADDR) begin
                        state    <= DONE;
                        load_err <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        state             <= LOAD;
                        stream.byte_ready <= 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= RUN;
                        core_reset  <= 1'b0;
                        cycle_count <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // A match on the limit cycle still counts as a pass.
                    if (a0 == expected_a0) begin
                        state      <= DONE;
                        pass       <= 1'b1;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        core_reset <= 1'b1;
                    end else if (cycle_count == RUN_LIMIT) begin
                        state      <= DONE;
                        timeout    <= 1'b1;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        core_reset <= 1'b1;
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                DONE: begin
`ifdef BOOT_SEQ_RERUN_EN
                    if (rerun && !load_err) begin
                        state       <= HOLD;
                        hold_cnt    <= '0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        cycle_count <= '0;
                    end
`endif
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// Randomized scoreboard bench for boot_sequencer: expected writes/results queued at stimulus time, checked by a monitor.
module tb_boot_sequencer;
    localparam int W  = 32;
    localparam int MW = 4;
    localparam int HC = 2;
    localparam int TO = 20;

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  expected_a0, a0;
    logic          rerun;
    logic          memEn;
    logic [W-1:0]  memAddr, memData;
    logic          core_reset, busy, done, pass, timeout, load_err;
    logic [31:0]   cycle_count;

    boot_sequencer_if bus();

    boot_sequencer #(.WIDTH(W), .MAX_WORDS(MW), .HOLD_CYCLES(HC), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .stream(bus.slave),
        .expected_a0(expected_a0), .a0(a0), .rerun(rerun),
        .memEn(memEn), .memAddr(memAddr), .memData(memData),
        .core_reset(core_reset), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .load_err(load_err), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic p; logic t; logic le; logic [31:0] cnt; } res_t;
    wr_t  wr_q[$];
    res_t res_q[$];
    bit   hold_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every write strobe, core release latency and every completion.
    int   cyc = 0;
    int   last_wr_cyc = 0;
    logic prev_done = 1'b0;
    logic prev_cr = 1'b1;
    always @(negedge clock) begin
        cyc++;
        if (memEn === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", memAddr, memData);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_addr", memAddr, e.addr);
                chk("wr_data", memData, e.data);
            end
            last_wr_cyc = cyc;
        end
        if (prev_cr === 1'b1 && core_reset === 1'b0 && hold_q.size() > 0) begin
            void'(hold_q.pop_front());
            chk("release_latency", 32'(cyc - last_wr_cyc), 32'd3);
        end
        if (prev_done === 1'b0 && done === 1'b1) begin
            if (res_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: pass %0b timeout %0b with nothing expected", pass, timeout);
            end else begin
                res_t r;
                r = res_q.pop_front();
                chk("res_pass", 32'(pass), 32'(r.p));
                chk("res_timeout", 32'(timeout), 32'(r.t));
                chk("res_load_err", 32'(load_err), 32'(r.le));
                chk("res_count", cycle_count, r.cnt);
                chk("done_core_reset", 32'(core_reset), 32'd1);
                chk("done_busy", 32'(busy), 32'd0);
                chk("done_byte_ready", 32'(bus.byte_ready), 32'd0);
            end
        end
        prev_done = done;
        prev_cr   = core_reset;
    end

    task automatic check_reset_outputs();
        chk("rst_memEn", 32'(memEn), 32'd0);
        chk("rst_memAddr", memAddr, 32'd0);
        chk("rst_memData", memData, 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_flags", {28'd0, done, pass, timeout, load_err}, 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        bus.byte_valid = 1'b0;
        @(negedge clock);
        check_reset_outputs();
        reset = 1'b1;
    endtask

    // Called at a negedge; returns at a negedge after the byte was taken.
    task automatic put_byte(input logic [7:0] d, input logic l);
        int n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = d;
        bus.byte_last  = l;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL byte_ready_wait: byte_ready %0b after %0d cycles, required 1", bus.byte_ready, n);
        end
        @(negedge clock);
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clock);
    endtask

    // Reference: little-endian packing; only complete words are written unless the image ends.
    task automatic load_image(input logic [7:0] b[$], input bit last);
        int nw;
        nw = last ? (b.size() + 3) / 4 : b.size() / 4;
        if (nw > MW) nw = MW;
        for (int i = 0; i < nw; i++) begin
            wr_t e;
            e.addr = 32'(i);
            e.data = 32'd0;
            for (int j = 0; j < 4; j++)
                if (4 * i + j < b.size()) e.data = e.data + (32'(b[4 * i + j]) << (8 * j));
            wr_q.push_back(e);
        end
        if (last) hold_q.push_back(1'b1);
        for (int i = 0; i < b.size(); i++)
            put_byte(b[i], (last && i == b.size() - 1) ? 1'b1 : 1'b0);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    // m < 0: a0 never matches. Match is placed on the RUN cycle whose count equals m.
    task automatic run_phase(input int m);
        res_t r;
        int   n = 0;
        int   c = 0;
        r.le = 1'b0;
        if (m >= 0 && m <= TO) begin r.p = 1'b1; r.t = 1'b0; r.cnt = 32'(m); end
        else begin r.p = 1'b0; r.t = 1'b1; r.cnt = 32'(TO); end
        res_q.push_back(r);
        while (core_reset !== 1'b0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL core_release: core_reset %0b after %0d cycles, required 0", core_reset, n);
        end
        while (done !== 1'b1 && c < TO + 10) begin
            if (c == m) a0 = expected_a0;
            @(negedge clock);
            c++;
        end
        wait_done("run_done");
    endtask

    task automatic new_scenario(input logic [31:0] exp);
        expected_a0 = exp;
        a0 = exp ^ 32'h1;
        do_reset();
    endtask

    logic [7:0] img[$];

    initial begin
        reset = 1'b0;
        rerun = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.byte_last  = 1'b0;
        expected_a0 = 32'd144;
        a0 = 32'd0;
        repeat (2) @(negedge clock);

        // Two full words, pass at RUN cycle 10.
        new_scenario(32'd144);
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load_image(img, 1'b1);
        run_phase(10);

`ifdef BOOT_SEQ_RERUN_EN
        @(negedge clock);
        rerun = 1'b1;
        @(negedge clock);
        rerun = 1'b0;
        chk("rerun_done_clr", 32'(done), 32'd0);
        chk("rerun_pass_clr", 32'(pass), 32'd0);
        chk("rerun_count_clr", cycle_count, 32'd0);
        chk("rerun_busy", 32'(busy), 32'd1);
        a0 = expected_a0 ^ 32'h1;
        run_phase(int'($urandom_range(0, TO)));
`else
        @(negedge clock);
        rerun = 1'b1;
        repeat (3) @(negedge clock);
        rerun = 1'b0;
        chk("rerun_ignored_done", 32'(done), 32'd1);
        chk("rerun_ignored_busy", 32'(busy), 32'd0);
        chk("rerun_ignored_pass", 32'(pass), 32'd1);
`endif

        // Partial final word, never matches: timeout at the limit.
        new_scenario($urandom);
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        load_image(img, 1'b1);
        run_phase(-1);

        // Match exactly on the limit cycle: pass wins.
        new_scenario($urandom);
        img = '{8'($urandom), 8'($urandom), 8'($urandom)};
        load_image(img, 1'b1);
        run_phase(TO);

        // Overflow: four full words without last, further bytes are refused.
        new_scenario($urandom);
        img.delete();
        for (int i = 0; i < 4 * MW; i++) img.push_back(8'($urandom));
        res_q.push_back('{p: 1'b0, t: 1'b0, le: 1'b1, cnt: 32'd0});
        load_image(img, 1'b0);
        wait_done("load_err_done");
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
        repeat (4) begin
            @(negedge clock);
            chk("overflow_byte_ready", 32'(bus.byte_ready), 32'd0);
        end
        chk("overflow_core_reset", 32'(core_reset), 32'd1);
        bus.byte_valid = 1'b0;

        // Reset in the middle of a load restarts at address 0 with a clean word.
        new_scenario($urandom);
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hEE};
        load_image(img, 1'b0);
        do_reset();
        img = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        load_image(img, 1'b1);
        run_phase(int'($urandom_range(0, 5)));

        // Random images and run outcomes, up to a full memory.
        repeat (6) begin
            int len;
            int m;
            new_scenario($urandom);
            len = int'($urandom_range(1, 4 * MW));
            img.delete();
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            load_image(img, 1'b1);
            m = int'($urandom_range(0, TO + 5)) - 1;
            run_phase(m);
        end

        repeat (3) @(negedge clock);
        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
        chk("res_q_empty", 32'(res_q.size()), 32'd0);
        chk("hold_q_empty", 32'(hold_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Bring-up controller for the 2-stage pipelined RV32I core.
- Assembles a byte stream into 32-bit words and writes them into core main memory through the core's memEn/memAddr/memData load port, with the core held in reset.
- Then releases the core and supervises the run: watches a0 for an expected value or a cycle timeout, and freezes the core on completion.

Parameters:
- WIDTH, 32, data word width (must be 32).
- MAX_WORDS, 1024, memory capacity in words; load overflow bound.
- HOLD_CYCLES, 2, cycles core_reset stays high after load completes (≥1).
- TIMEOUT_CYCLES, 5000, maximum RUN cycle count before timeout.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low
- byte_valid  in  1  load byte present
- byte_data  in  8  load byte
- byte_last  in  1  qualifies byte_valid; final byte of image
- byte_ready  out  1  sequencer accepts byte this cycle
- expected_a0  in  WIDTH  pass value compared against a0
- a0  in  WIDTH  core register x10
- rerun  in  1  restart request from DONE (see Optional Feature)
- memEn  out  1  core memory write strobe
- memAddr  out  WIDTH  word index (0,1,2,…)
- memData  out  WIDTH  word to write
- core_reset  out  1  active-high reset to core
- busy  out  1  state ≠ DONE
- done  out  1  sticky completion flag
- pass  out  1  a0 matched
- timeout  out  1  run expired
- load_err  out  1  image exceeded MAX_WORDS
- cycle_count  out  32  RUN cycles elapsed

Behaviour:
- Reset (reset==0 at edge) enters LOAD.
  - Values: byte_cnt=0, word_addr=0, assembly reg=0.
  - Outputs: memEn=0, memAddr=0, memData=0, core_reset=1, byte_ready=1, busy=1, done/pass/timeout/load_err=0, cycle_count=0.
  - Applies from any state, including mid-load or mid-run.
  - Memory already written is not cleared.
- States: LOAD, WRITE, HOLD, RUN, DONE. All outputs are registered.
- LOAD: byte_ready=1.
  - Accept when byte_valid&&byte_ready; byte k goes to bits [8k+7:8k] (little-endian).
  - After byte 3 or a byte_last byte: go to WRITE. Unfilled bytes of a partial word are zero.
  - Remember whether the word ended on byte_last.
- WRITE: exactly one cycle, byte_ready=0, memEn=1, memAddr=word_addr, memData=assembled word.
  - Next edge: word_addr+1, byte_cnt=0, assembly reg cleared.
  - If last was seen: go to HOLD.
  - Else if word_addr+1==MAX_WORDS: load_err=1, done=1, go to DONE; core stays in reset.
  - Else return to LOAD.
- Throughput: max 4 bytes per 5 cycles. The source holds byte_valid/byte_data while byte_ready=0.
- HOLD: core_reset=1, byte_ready=0 for HOLD_CYCLES cycles, then RUN.
- RUN: core_reset=0; cycle_count is 0 on entry. Each edge:
  - If a0==expected_a0: pass=1, done=1, go to DONE.
  - Else if cycle_count==TIMEOUT_CYCLES: timeout=1, done=1, go to DONE.
  - Else cycle_count+1.
  - Match and limit in the same cycle: pass wins.
  - a0 is compared starting with the first RUN cycle.
- DONE: core_reset=1 (core frozen), byte_ready=0, busy=0, flags and cycle_count held.
- byte_valid outside LOAD is ignored and not consumed.

Optional Feature:
- Macro: BOOT_SEQ_RERUN_EN.
- Defined: rerun==1 in DONE, except after load_err, does the following at the next edge:
  - clears pass/timeout/done and cycle_count;
  - enters HOLD without reloading memory (memory image reused).
- Undefined: the rerun port exists but is ignored; DONE is left only by reset.

Test Plan:
- Bytes 13 00 00 00 93 00 10 00, last on 8th → memEn pulses: addr 0 data 0x00000013, then addr 1 data 0x00100093; core_reset falls 2 cycles after the second WRITE.
- Bytes AA BB CC DD 11 22, last on 6th → addr 0 data 0xDDCCBBAA; addr 1 data 0x00002211.
- expected_a0=144, a0 driven to 144 at RUN cycle 10 → next edge done=1, pass=1, core_reset=1, cycle_count=10.
- TIMEOUT_CYCLES=20, a0 never matches → timeout=1, cycle_count=20 after 21 RUN cycles. Repeat with a0 matching exactly at count 20 → pass=1, timeout=0.
- MAX_WORDS=4, 20 bytes with no last → 4 writes at addr 0..3, then load_err=1, done=1, core_reset=1, byte_ready=0.
- reset low after 5 bytes → LOAD, word_addr=0, memEn=0 next cycle. With BOOT_SEQ_RERUN_EN: after a pass, rerun pulse → HOLD, flags cleared, pass again with no memEn activity.
